// File: rtl/control_de_modo_multi_pkg.sv
// Shared scancodes, state encoding and decode helpers for the keyboard edit-mode controller.
package control_pkg;

  localparam logic [7:0] KEY_HOME  = 8'h6C;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_PGUP  = 8'h7D;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int TMO_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT     = 2'd1,
    ST_BRK_IDLE = 2'd2,
    ST_BRK_EDIT = 2'd3
  } state_e;

  function automatic logic is_entry_key(input logic [7:0] code);
    return (code == KEY_HOME) || (code == KEY_UP) || (code == KEY_PGUP);
  endfunction

endpackage

// File: rtl/control_de_modo_multi_timeout_cnt.sv
// Inactivity counter: counts while enabled, pulses expire on the cycle it sits at TERM-1.
module timeout_cnt #(
  parameter int           W    = 24,
  parameter logic [W-1:0] TERM = W'(16)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_term;

  // A terminal count of zero disables expiry entirely.
  assign at_term  = (TERM != '0) && (cnt_q == TERM - W'(1));
  assign expire_o = en_i && !clr_i && at_term;

  // NOTE: cnt_d gets a default first so no path through this block can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_term ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_de_modo_multi.sv
// Keyboard edit-mode controller: decodes PS/2 scancodes into field select and inc/dec/commit pulses.
module control_de_modo_multi
  import control_pkg::*;
#(
  parameter int          N_CAMPOS    = 3,
  parameter int          CW          = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
  parameter logic [7:0]  FIN_CODE    = 8'd1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    Tecla,
  input  logic          got_data,
  input  logic [7:0]    reset_escritura,
  output logic          Senal,
  output logic [CW-1:0] campo,
  output logic          inc,
  output logic          dec,
  output logic          commit,
  output logic          timeout
);

  localparam logic [CW-1:0] CAMPO_MAX = CW'(N_CAMPOS - 1);

  state_e        state_q;
  logic          senal_q;
  logic [CW-1:0] campo_q;
  logic          inc_q, dec_q, commit_q, timeout_q;

  logic fin_hit, in_edit, tmo_clr, tmo_en, tmo_expire;

  assign fin_hit = (reset_escritura == FIN_CODE);
  assign in_edit = (state_q == ST_EDIT) || (state_q == ST_BRK_EDIT);

  // Break prefix and the byte it swallows leave the inactivity count untouched.
  assign tmo_en  = in_edit && !got_data;
  assign tmo_clr = !in_edit || fin_hit ||
                   ((state_q == ST_EDIT) && got_data && (Tecla != PS2_BRK));

  timeout_cnt #(
    .W    (TMO_W),
    .TERM (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      senal_q   <= 1'b0;
      campo_q   <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      if (fin_hit) begin
        state_q <= ST_IDLE;
        senal_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (got_data) begin
              if (Tecla == PS2_BRK) begin
                state_q <= ST_BRK_IDLE;
              end else if (is_entry_key(Tecla)) begin
                state_q <= ST_EDIT;
                senal_q <= 1'b1;
                campo_q <= '0;
              end
            end
          end
          ST_BRK_IDLE: begin
            if (got_data) state_q <= ST_IDLE;
          end
          ST_EDIT: begin
            if (got_data) begin
              case (Tecla)
                PS2_BRK:   state_q <= ST_BRK_EDIT;
                KEY_LEFT:  campo_q <= (campo_q == '0) ? CAMPO_MAX : campo_q - CW'(1);
                KEY_RIGHT: campo_q <= (campo_q == CAMPO_MAX) ? '0 : campo_q + CW'(1);
                KEY_UP:    inc_q    <= 1'b1;
                KEY_DOWN:  dec_q    <= 1'b1;
                KEY_ENTER: commit_q <= 1'b1;
                KEY_ESC: begin
                  state_q <= ST_IDLE;
                  senal_q <= 1'b0;
                end
                default: ;
              endcase
            end else if (tmo_expire) begin
              state_q   <= ST_IDLE;
              senal_q   <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
          ST_BRK_EDIT: begin
            if (got_data) begin
              state_q <= ST_EDIT;
            end else if (tmo_expire) begin
              state_q   <= ST_IDLE;
              senal_q   <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign Senal   = senal_q;
  assign campo   = campo_q;
  assign inc     = inc_q;
  assign dec     = dec_q;
  assign commit  = commit_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_control_de_modo_multi.sv
// Bench for control_de_modo_multi: directed key sequences, a cycle-level reference model and literal checks.
module tb_control_de_modo_multi;

  localparam int N  = 3;
  localparam int T  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] Tecla = 8'h00;
  logic       got_data = 1'b0;
  logic [7:0] reset_escritura = 8'h00;
  logic       Senal;
  logic [1:0] campo;
  logic       inc, dec, commit, timeout;

  int n_checks = 0;
  int n_err    = 0;

  control_de_modo_multi #(
    .N_CAMPOS    (N),
    .CW          (2),
    .TIMEOUT_CYC (24'(T)),
    .FIN_CODE    (8'd1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .Tecla           (Tecla),
    .got_data        (got_data),
    .reset_escritura (reset_escritura),
    .Senal           (Senal),
    .campo           (campo),
    .inc             (inc),
    .dec             (dec),
    .commit          (commit),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edit-mode flag, pending break byte, selected field and quiet-cycle count.
  bit m_edit, m_swallow, m_inc, m_dec, m_commit, m_timeout;
  int m_campo, m_quiet;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edit = 0; m_swallow = 0; m_campo = 0; m_quiet = 0;
      m_inc = 0; m_dec = 0; m_commit = 0; m_timeout = 0;
    end else begin
      m_inc = 0; m_dec = 0; m_commit = 0; m_timeout = 0;
      if (reset_escritura == 8'd1) begin
        m_edit = 0; m_swallow = 0; m_quiet = 0;
      end else if (!m_edit) begin
        if (got_data) begin
          if (m_swallow) m_swallow = 0;
          else if (Tecla == 8'hF0) m_swallow = 1;
          else if (Tecla inside {8'h6C, 8'h75, 8'h7D}) begin
            m_edit = 1; m_campo = 0; m_quiet = 0;
          end
        end
      end else begin
        if (got_data && m_swallow) m_swallow = 0;
        else if (got_data && Tecla == 8'hF0) m_swallow = 1;
        else if (got_data) begin
          m_quiet = 0;
          case (Tecla)
            8'h6B: m_campo = (m_campo + N - 1) % N;
            8'h74: m_campo = (m_campo + 1) % N;
            8'h75: m_inc = 1;
            8'h72: m_dec = 1;
            8'h5A: m_commit = 1;
            8'h76: m_edit = 0;
            default: ;
          endcase
        end else if (m_quiet == T - 1) begin
          m_edit = 0; m_swallow = 0; m_quiet = 0; m_timeout = 1;
        end else begin
          m_quiet++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_senal",   int'(Senal),   int'(m_edit));
    check("model_campo",   int'(campo),   m_campo);
    check("model_inc",     int'(inc),     int'(m_inc));
    check("model_dec",     int'(dec),     int'(m_dec));
    check("model_commit",  int'(commit),  int'(m_commit));
    check("model_timeout", int'(timeout), int'(m_timeout));
    check("pulse_onehot",  int'($countones({inc, dec, commit, timeout}) <= 1), 1);
  end

  task automatic send(input logic [7:0] code);
    @(posedge clk); #1;
    Tecla = code; got_data = 1'b1;
    @(posedge clk); #1;
    got_data = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    #1;
    check("reset_senal", int'(Senal), 0);
    check("reset_campo", int'(campo), 0);

    // Ignored codes in IDLE, then entry with UP
    send(8'hE0);
    send(8'h5A);
    check("idle_ignore", int'(Senal), 0);
    send(8'h75);
    check("entry_senal", int'(Senal), 1);
    check("entry_campo", int'(campo), 0);
    check("entry_no_inc", int'(inc), 0);

    // Field wrap in both directions
    send(8'h74); check("right1", int'(campo), 1);
    send(8'h74); check("right2", int'(campo), 2);
    send(8'h74); check("right_wrap", int'(campo), 0);
    send(8'h6B); check("left_wrap", int'(campo), 2);

    // Break-released ESC is swallowed; bare ESC exits without commit
    send(8'hF0);
    send(8'h76);
    check("brk_esc_stays", int'(Senal), 1);
    send(8'h76);
    check("esc_exit", int'(Senal), 0);
    check("esc_no_commit", int'(commit), 0);
    check("campo_retained", int'(campo), 2);

    // Pulses in EDIT
    send(8'h6C);
    check("reentry_campo", int'(campo), 0);
    send(8'h75); check("inc_pulse", int'(inc), 1);
    send(8'h72); check("dec_pulse", int'(dec), 1);
    check("dec_no_inc", int'(inc), 0);
    send(8'h5A); check("commit_pulse", int'(commit), 1);
    check("commit_stays_edit", int'(Senal), 1);
    @(posedge clk); #1;
    check("commit_one_cycle", int'(commit), 0);

    // Timeout after 16 quiet cycles
    send(8'h76);
    send(8'h7D);
    repeat (T - 1) @(posedge clk);
    #1;
    check("pre_timeout_senal", int'(Senal), 1);
    check("pre_timeout_pulse", int'(timeout), 0);
    @(posedge clk); #1;
    check("timeout_pulse", int'(timeout), 1);
    check("timeout_exit", int'(Senal), 0);

    // Key landing on the expiry cycle suppresses the timeout
    send(8'h75);
    repeat (T - 2) @(posedge clk);
    send(8'h1C);
    check("key_on_expiry_no_tmo", int'(timeout), 0);
    check("key_on_expiry_senal", int'(Senal), 1);
    repeat (3) @(posedge clk);
    #1;
    check("still_edit", int'(Senal), 1);

    // Write-done status beats ENTER
    @(posedge clk); #1;
    Tecla = 8'h5A; got_data = 1'b1; reset_escritura = 8'd1;
    @(posedge clk); #1;
    got_data = 1'b0; reset_escritura = 8'd0;
    check("fin_exit", int'(Senal), 0);
    check("fin_no_commit", int'(commit), 0);

    // Write-done status blocks entry from IDLE
    @(posedge clk); #1;
    Tecla = 8'h75; got_data = 1'b1; reset_escritura = 8'd1;
    @(posedge clk); #1;
    got_data = 1'b0; reset_escritura = 8'd0;
    check("fin_blocks_entry", int'(Senal), 0);

    // Asynchronous reset mid-EDIT
    send(8'h75);
    send(8'h74);
    check("pre_reset_campo", int'(campo), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_senal", int'(Senal), 0);
    check("async_campo", int'(campo), 0);
    check("async_pulses", int'({inc, dec, commit, timeout}), 0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    send(8'h6C);
    check("post_reset_entry", int'(Senal), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
